// File: rtl/ws2801_multi_driver.sv
// Multi-channel WS2801 strip driver: double-buffered frame capture, global brightness
// scaling, lockstep serial shift-out on a shared clock, then an enforced latch gap.
module ws2801_multi_driver #(
    parameter int LEDS         = 50,
    parameter int CHANNELS     = 2,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 391
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CHANNELS*24*LEDS-1:0]  led_rgb,
    input  logic [7:0]                   brightness,
    output logic                         busy,
    output logic                         done,
    output logic [CHANNELS-1:0]          dOut,
    output logic                         clkOut
);

    localparam int NBYTES = 3 * LEDS;
    localparam int BYW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int HW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LW     = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [BYW-1:0] LAST_BYTE  = BYW'(NBYTES - 1);
    localparam logic [HW-1:0]  HALF_LAST  = HW'(CLK_DIV - 1);
    localparam logic [LW-1:0]  LATCH_LAST = LW'(LATCH_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t                         state;
    logic [CHANNELS*24*LEDS-1:0]    frame_q;
    logic [7:0]                     bright_q;
    logic [BYW-1:0]                 byte_cnt;
    logic [2:0]                     bit_cnt;
    logic [HW-1:0]                  half_cnt;
    logic [LW-1:0]                  latch_cnt;
    logic [7:0]                     shreg [CHANNELS];
    logic [7:0]                     seq [CHANNELS][NBYTES];
    logic [7:0]                     next_byte [CHANNELS];
    logic [CHANNELS-1:0]            next_msb;
    logic [CHANNELS-1:0]            shift_msb;
    logic [BYW-1:0]                 sel;
    logic                           capture;
    logic                           fall;
    logic                           load_next;
    logic                           shift_bit;

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [16:0] prod;
        prod = {9'd0, c} * {8'd0, ({1'b0, b} + 9'd1)};
        return prod[15:8];
    endfunction

    // Shadow frame reordered into transmission order: LED-major, then R, G, B.
    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        for (genvar b = 0; b < NBYTES; b++) begin : g_byte
            assign seq[k][b] = frame_q[(k*LEDS + b/3)*24 + 16 - (b%3)*8 +: 8];
        end
    end

    always_comb begin
        capture   = (state == IDLE) && start;
        fall      = (state == SHIFT) && (half_cnt == HALF_LAST) && clkOut;
        load_next = (state == LOAD) || (fall && (bit_cnt == 3'd7) && (byte_cnt != LAST_BYTE));
        shift_bit = fall && (bit_cnt != 3'd7);
        sel       = ((state == LOAD) || (byte_cnt == LAST_BYTE)) ? '0 : byte_cnt + 1'b1;
        for (int k = 0; k < CHANNELS; k++) begin
            next_byte[k] = scale(seq[k][sel], bright_q);
            next_msb[k]  = next_byte[k][7];
            shift_msb[k] = shreg[k][6];
        end
    end

    // Data path: shadow registers and per-channel byte shifters, no reset needed.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame_q  <= led_rgb;
            bright_q <= brightness;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            if (load_next)
                shreg[k] <= next_byte[k];
            else if (shift_bit)
                shreg[k] <= {shreg[k][6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            clkOut    <= 1'b0;
            dOut      <= '0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
            half_cnt  <= '0;
            latch_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    dOut     <= next_msb;
                    byte_cnt <= '0;
                    bit_cnt  <= '0;
                    half_cnt <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (half_cnt != HALF_LAST) begin
                        half_cnt <= half_cnt + 1'b1;
                    end else begin
                        half_cnt <= '0;
                        if (!clkOut) begin
                            clkOut <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit, byte, or the latch gap.
                            clkOut <= 1'b0;
                            if (bit_cnt != 3'd7) begin
                                bit_cnt <= bit_cnt + 1'b1;
                                dOut    <= shift_msb;
                            end else begin
                                bit_cnt <= '0;
                                if (byte_cnt == LAST_BYTE) begin
                                    byte_cnt  <= '0;
                                    dOut      <= '0;
                                    latch_cnt <= '0;
                                    state     <= LATCH;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                    dOut     <= next_msb;
                                end
                            end
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == LATCH_LAST) begin
                        latch_cnt <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ws2801_multi_driver.md
# ws2801_multi_driver

Parametrised multi-channel WS2801 strip driver: captures a full frame for CHANNELS independent strips on `start`, applies a global 8-bit brightness scale per colour byte, and shifts all channels out in lockstep on a shared serial clock, followed by an enforced latch gap. It sits between the pattern/frame source and the GPIO pins, replacing the single-strip, unscaled driver. It adds three behaviours that driver lacks: multiple channels, brightness scaling, and a double-buffered frame, so the source may change `led_rgb` while a frame is in flight.

## Interface
- `LEDS`, 50, LEDs per channel (≥1)
- `CHANNELS`, 2, number of parallel strips (≥1)
- `CLK_DIV`, 4, `clk` cycles per serial-clock half period (≥1)
- `LATCH_CYCLES`, 391, `clk` cycles of clock-low idle after a frame (≥1; ≥500 µs at 781250 Hz)

- `clk`  in  1  system clock; the only clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  frame request, sampled only in IDLE
- `led_rgb`  in  CHANNELS*24*LEDS  frame; LED i of channel k at `[(k*LEDS+i)*24 +: 24]`, with [23:16]=R, [15:8]=G, [7:0]=B
- `brightness`  in  8  global scale, sampled with the frame
- `busy`  out  1  high from the cycle after `start` is accepted until the frame completes
- `done`  out  1  one-cycle pulse at frame completion
- `dOut`  out  CHANNELS  serial data per channel
- `clkOut`  out  1  shared serial clock

## Operation
- States: IDLE, LOAD, SHIFT, LATCH.
- IDLE:
  - `start`=1 at an edge captures `led_rgb` and `brightness` into shadow registers, sets `busy`, and moves to LOAD.
  - `start` outside IDLE is ignored and is not queued.
- LOAD, 1 cycle: the scaled byte 0 (R of LED 0) of every channel is loaded into per-channel 8-bit shift registers. Moves to SHIFT.
- SHIFT:
  - Per bit: `clkOut`=0 for CLK_DIV cycles, then `clkOut`=1 for CLK_DIV cycles.
  - `dOut[k]` = MSB of channel k's byte register; it changes only at the edge where `clkOut` falls.
  - Order per channel: LED 0 first, then R, G, B, each MSB first. 24*LEDS bits total.
  - After the 8th bit of a byte, the next scaled byte loads at the same edge `clkOut` falls. There are no gap cycles.
- Scaling: out = (c * (brightness+1)) >> 8, computed on 16 bits with the upper 8 taken. brightness=255 passes data through unchanged; brightness=0 gives 0. CHANNELS multipliers are shared across bytes, one byte per channel at a time.
- LATCH:
  - `clkOut`=0 and `dOut`=0 for LATCH_CYCLES cycles.
  - Then: IDLE, `busy`=0, and `done`=1 for exactly that first IDLE cycle.
- A `start` sampled in the `done` cycle is accepted normally (back-to-back frames).
- Changes to `led_rgb`/`brightness` after capture have no effect on the frame in flight.

## Timing
- Reset values: `busy`=0, `done`=0, `clkOut`=0, `dOut`='0; state IDLE; byte and bit counters 0.
- `rst` mid-frame:
  - The next cycle is IDLE with all outputs at their reset values.
  - No `done` pulse. The partial frame is abandoned.
  - `start` and `rst` high together: reset wins.
- Let E be the edge sampling `start`:
  - `busy`=1 from E+1.
  - First `clkOut` low phase starts at E+2.
  - First `clkOut` rising edge at E+2+CLK_DIV.
  - LATCH begins at E+2+48*LEDS*CLK_DIV.
  - `done`=1 at E+2+48*LEDS*CLK_DIV+LATCH_CYCLES.
- Counters:
  - Bit counter is 0..7.
  - Byte counter is 0..3*LEDS-1 and wraps to LATCH.
  - Half-period counter is 0..CLK_DIV-1.
  - Widths use $clog2 with a minimum of 1 bit.
- `dOut` is stable for the full `clkOut` high phase and for CLK_DIV cycles before each rising edge.

## Test plan
- Latency: LEDS=2, CHANNELS=2, CLK_DIV=2, LATCH_CYCLES=10, pulse `start` → `done` exactly 204 cycles after the sampling edge, `busy` high for 203 cycles, exactly 48 `clkOut` rising edges.
- Data order and scaling:
  - ch0 LED0=0xFF8010, LED1=0x000001; ch1 all 0xA5A5A5.
  - brightness=0xFF → bits sampled at `clkOut` rises reproduce the input exactly per channel.
  - brightness=0x80 → ch0 LED0 sampled as 0x804008; 0x01 scales to 0x00.
- Zero brightness: brightness=0x00, any frame → `dOut` stays 0 throughout, and `clkOut` still toggles 48*LEDS times.
- Double buffering: change `led_rgb` and `brightness` one cycle after `start` → transmitted data equals the values captured at `start`.
- Back-to-back and ignore:
  - `start` held high continuously → a new frame begins in each `done` cycle.
  - Extra `start` pulses during SHIFT/LATCH are ignored; frame count is unchanged.
- Reset mid-SHIFT: assert `rst` at bit 13 → the next cycle has `busy`=0, `clkOut`=0, `dOut`=0, and no `done`. A subsequent `start` produces a complete, correct frame.
